// File: rtl/adc_pkg.sv
// Shared types and width helpers for the ADC channel averager slice.
package adc_pkg;

    localparam int ADC_DATA_W = 12;
    localparam int ADC_CH_W   = 5;

    typedef struct packed {
        logic [ADC_CH_W-1:0]          channel;
        logic signed [ADC_DATA_W-1:0] data;
    } adc_sample_t;

    // Accumulator must hold 2^decim_log2 full-scale samples without wrapping.
    function automatic int acc_w(input int data_w, input int decim_log2);
        return data_w + decim_log2;
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// First-word-fall-through FIFO carrying averaged samples with their channel tag.
module adc_sample_fifo
    import adc_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = adc_sample_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    T            mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? T'('0) : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/adc_channel_averager.sv
// Per-channel decimating averager between the ADC response stream and a backpressured result stream.
module adc_channel_averager
    import adc_pkg::*;
#(
    parameter int DATA_W     = ADC_DATA_W,
    parameter int CH_W       = ADC_CH_W,
    parameter int NUM_CH     = 8,
    parameter int DECIM_LOG2 = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk_adc_clk,
    input  logic                     reset_reset_n,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_channel,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [NUM_CH-1:0]        cfg_ch_mask,
    input  logic                     cfg_clear_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_channel,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     ovf_flag,
    output logic [15:0]              drop_count
);

    localparam int ACC_W = acc_w(DATA_W, DECIM_LOG2);
    localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);

    typedef struct packed {
        logic [CH_W-1:0]          channel;
        logic signed [DATA_W-1:0] data;
    } sample_t;

    function automatic logic signed [DATA_W-1:0] to_signed(input logic [DATA_W-1:0] raw);
        return {~raw[DATA_W-1], raw[DATA_W-2:0]};
    endfunction

    // Arithmetic shift floors toward minus infinity; the average always fits DATA_W.
    function automatic logic signed [DATA_W-1:0] avg_shift(input logic signed [ACC_W-1:0] sum);
        logic signed [ACC_W-1:0] sh;
        sh = sum >>> DECIM_LOG2;
        return sh[DATA_W-1:0];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic signed [ACC_W-1:0]  acc [NUM_CH];
    logic [CNT_W-1:0]         cnt [NUM_CH];

    logic [NUM_CH-1:0]        hit;
    logic signed [ACC_W-1:0]  sel_acc;
    logic [CNT_W-1:0]         sel_cnt;
    logic signed [DATA_W-1:0] sample_p0;
    logic signed [ACC_W-1:0]  sample_ext_p0;
    logic signed [ACC_W-1:0]  sum_p0;
    logic                     vld_p0;
    logic                     done_p0;
    sample_t                  result_p0;
    sample_t                  head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     pop;
    logic                     drop;
    logic                     push;

    // Stage p0: channel decode, accumulate, completion -> FIFO push
    always_comb begin
        hit     = '0;
        sel_acc = '0;
        sel_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = in_valid && cfg_ch_mask[i] && (in_channel == CH_W'(i));
            if (hit[i]) begin
                sel_acc = acc[i];
                sel_cnt = cnt[i];
            end
        end
    end

    assign sample_p0     = to_signed(in_data);
    assign sample_ext_p0 = sample_p0;
    assign sum_p0        = sel_acc + sample_ext_p0;
    assign vld_p0        = |hit;
    assign done_p0       = vld_p0 && (sel_cnt == CNT_LAST);

    assign result_p0.channel = in_channel;
    assign result_p0.data    = avg_shift(sum_p0);

    assign pop  = out_valid && out_ready;
    assign drop = done_p0 && fifo_full && !pop;
    assign push = done_p0 && !drop;

    // A disabled channel is held cleared so re-enabling starts a fresh average.
    always_ff @(posedge clk_adc_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!cfg_ch_mask[i] || (hit[i] && done_p0)) begin
                    acc[i] <= '0;
                    cnt[i] <= '0;
                end else if (hit[i]) begin
                    acc[i] <= sum_p0;
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A drop in the same cycle as a clear leaves exactly one recorded drop.
    always_ff @(posedge clk_adc_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ovf_flag   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            ovf_flag   <= 1'b1;
            drop_count <= cfg_clear_ovf ? 16'd1 : sat_inc(drop_count);
        end else if (cfg_clear_ovf) begin
            ovf_flag   <= 1'b0;
            drop_count <= '0;
        end
    end

    // Stage p1: result FIFO, first word visible the cycle after it is pushed
    adc_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (sample_t)
    ) u_fifo (
        .clk       (clk_adc_clk),
        .rst_n     (reset_reset_n),
        .push      (push),
        .push_data (result_p0),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign out_channel = head.channel;
    assign out_data    = head.data;

endmodule

// File: tb/tb_adc_channel_averager.sv
// Directed-vector bench for adc_channel_averager (4-sample and pass-through instances).
module tb_adc_channel_averager;

    logic              clk = 1'b0;
    logic              reset_reset_n;

    logic              in_valid, cfg_clear_ovf, out_ready;
    logic [4:0]        in_channel;
    logic [11:0]       in_data;
    logic [7:0]        cfg_ch_mask;
    logic              out_valid, ovf_flag;
    logic [4:0]        out_channel;
    logic signed [11:0] out_data;
    logic [15:0]       drop_count;

    logic              in0_valid;
    logic [4:0]        in0_channel;
    logic [11:0]       in0_data;
    logic              out0_valid, ovf0_flag;
    logic [4:0]        out0_channel;
    logic signed [11:0] out0_data;
    logic [15:0]       drop0_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adc_channel_averager #(
        .DATA_W(12), .CH_W(5), .NUM_CH(8), .DECIM_LOG2(2), .FIFO_DEPTH(8)
    ) dut (
        .clk_adc_clk   (clk),
        .reset_reset_n (reset_reset_n),
        .in_valid      (in_valid),
        .in_channel    (in_channel),
        .in_data       (in_data),
        .cfg_ch_mask   (cfg_ch_mask),
        .cfg_clear_ovf (cfg_clear_ovf),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_channel   (out_channel),
        .out_data      (out_data),
        .ovf_flag      (ovf_flag),
        .drop_count    (drop_count)
    );

    adc_channel_averager #(
        .DATA_W(12), .CH_W(5), .NUM_CH(8), .DECIM_LOG2(0), .FIFO_DEPTH(8)
    ) dut0 (
        .clk_adc_clk   (clk),
        .reset_reset_n (reset_reset_n),
        .in_valid      (in0_valid),
        .in_channel    (in0_channel),
        .in_data       (in0_data),
        .cfg_ch_mask   (8'h01),
        .cfg_clear_ovf (1'b0),
        .out_valid     (out0_valid),
        .out_ready     (1'b1),
        .out_channel   (out0_channel),
        .out_data      (out0_data),
        .ovf_flag      (ovf0_flag),
        .drop_count    (drop0_count)
    );

    task automatic send(input logic [4:0] ch, input logic [11:0] d);
        in_valid   = 1'b1;
        in_channel = ch;
        in_data    = d;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
    endtask

    task automatic send0(input logic [4:0] ch, input logic [11:0] d);
        in0_valid   = 1'b1;
        in0_channel = ch;
        in0_data    = d;
        @(posedge clk);
        #1;
        in0_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 12'sd0)  begin errors++; $display("FAIL reset_data got %0d want 0", out_data); end
        checks++; if (out_channel !== 5'd0) begin errors++; $display("FAIL reset_channel got %0d want 0", out_channel); end
        checks++; if (ovf_flag !== 1'b0)    begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_flag); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_count); end
        reset_reset_n = 1'b1;
    endtask

    task automatic test_average();
        logic [11:0] vec [4];
        vec[0] = 12'h800; vec[1] = 12'h804; vec[2] = 12'h808; vec[3] = 12'h80C;
        cfg_ch_mask = 8'b0000_1000;
        out_ready   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(5'd3, vec[k]);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL avg_early_valid sample %0d got %b want 0", k, out_valid); end
        end
        send(5'd3, vec[3]);
        checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL avg_valid got %b want 1", out_valid); end
        checks++; if (out_channel !== 5'd3) begin errors++; $display("FAIL avg_channel got %0d want 3", out_channel); end
        checks++; if (out_data !== 12'sd6)  begin errors++; $display("FAIL avg_data got %0d want 6", out_data); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL avg_popped got %b want 0", out_valid); end
    endtask

    task automatic test_signed_edges();
        logic [11:0]        raw [3];
        logic signed [11:0] exp [3];
        raw[0] = 12'h000; exp[0] = -12'sd2048;
        raw[1] = 12'hFFF; exp[1] = 12'sd2047;
        raw[2] = 12'h800; exp[2] = 12'sd0;
        for (int k = 0; k < 3; k++) begin
            send0(5'd0, raw[k]);
            checks++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL pass_valid %0d got %b want 1", k, out0_valid); end
            checks++; if (out0_data !== exp[k]) begin errors++; $display("FAIL pass_data %0d got %0d want %0d", k, out0_data, exp[k]); end
        end
    endtask

    task automatic test_interleave();
        cfg_ch_mask = 8'b0000_0011;
        out_ready   = 1'b1;
        send(5'd0, 12'h810);
        send(5'd1, 12'h7F0);
        send(5'd9, 12'hFFF);
        send(5'd2, 12'hFFF);
        send(5'd0, 12'h820);
        send(5'd1, 12'h7E0);
        send(5'd0, 12'h830);
        send(5'd1, 12'h7D0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ilv_no_early got %b want 0", out_valid); end
        send(5'd0, 12'h840);
        checks++; if (out_channel !== 5'd0) begin errors++; $display("FAIL ilv_ch0_channel got %0d want 0", out_channel); end
        checks++; if (out_data !== 12'sd40) begin errors++; $display("FAIL ilv_ch0_data got %0d want 40", out_data); end
        send(5'd1, 12'h7BF);
        checks++; if (out_channel !== 5'd1) begin errors++; $display("FAIL ilv_ch1_channel got %0d want 1", out_channel); end
        checks++; if (out_data !== -12'sd41) begin errors++; $display("FAIL ilv_ch1_data got %0d want -41", out_data); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ilv_drained got %b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        cfg_ch_mask = 8'b0000_1000;
        out_ready   = 1'b0;
        for (int r = 0; r < 10; r++)
            for (int k = 0; k < 4; k++) send(5'd3, 12'h800 + 12'(r));
        checks++; if (ovf_flag !== 1'b1)    begin errors++; $display("FAIL ovf_flag got %b want 1", ovf_flag); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_count got %0d want 2", drop_count); end
        @(posedge clk); #1;
        checks++; if (out_data !== 12'sd0 || out_valid !== 1'b1) begin errors++; $display("FAIL ovf_hold got v=%b d=%0d want v=1 d=0", out_valid, out_data); end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 12'(k) || out_channel !== 5'd3) begin
                errors++; $display("FAIL drain_%0d got v=%b ch=%0d d=%0d want v=1 ch=3 d=%0d", k, out_valid, out_channel, out_data, k);
            end
            @(posedge clk); #1;
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", out_valid); end
    endtask

    task automatic test_full_pop_push();
        out_ready = 1'b0;
        for (int r = 20; r < 28; r++)
            for (int k = 0; k < 4; k++) send(5'd3, 12'h800 + 12'(r));
        for (int k = 0; k < 3; k++) send(5'd3, 12'h800 + 12'd28);
        out_ready = 1'b1;
        send(5'd3, 12'h800 + 12'd28);
        out_ready = 1'b0;
        checks++; if (drop_count !== 16'd2)   begin errors++; $display("FAIL popush_count got %0d want 2", drop_count); end
        checks++; if (out_data !== 12'sd21)   begin errors++; $display("FAIL popush_head got %0d want 21", out_data); end
        for (int k = 0; k < 3; k++) send(5'd3, 12'h800 + 12'd29);
        cfg_clear_ovf = 1'b1;
        send(5'd3, 12'h800 + 12'd29);
        cfg_clear_ovf = 1'b0;
        checks++; if (ovf_flag !== 1'b1)      begin errors++; $display("FAIL clrdrop_flag got %b want 1", ovf_flag); end
        checks++; if (drop_count !== 16'd1)   begin errors++; $display("FAIL clrdrop_count got %0d want 1", drop_count); end
        checks++; if (out_data !== 12'sd21)   begin errors++; $display("FAIL clrdrop_head got %0d want 21", out_data); end
        cfg_clear_ovf = 1'b1;
        @(posedge clk); #1;
        cfg_clear_ovf = 1'b0;
        checks++; if (ovf_flag !== 1'b0 || drop_count !== 16'd0) begin
            errors++; $display("FAIL clear_only got flag=%b count=%0d want 0/0", ovf_flag, drop_count);
        end
    endtask

    task automatic test_reset_mid();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b want 1", out_valid); end
        send(5'd3, 12'h900);
        send(5'd3, 12'h900);
        reset_reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 12'sd0 || out_channel !== 5'd0) begin
            errors++; $display("FAIL async_reset got v=%b ch=%0d d=%0d want 0/0/0", out_valid, out_channel, out_data);
        end
        @(posedge clk); #1;
        reset_reset_n = 1'b1;
        out_ready = 1'b1;
        send(5'd3, 12'h804);
        send(5'd3, 12'h808);
        send(5'd3, 12'h80C);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_early got %b want 0", out_valid); end
        send(5'd3, 12'h810);
        checks++; if (out_valid !== 1'b1 || out_data !== 12'sd10 || out_channel !== 5'd3) begin
            errors++; $display("FAIL post_reset_avg got v=%b ch=%0d d=%0d want 1/3/10", out_valid, out_channel, out_data);
        end
    endtask

    initial begin
        in_valid      = 1'b0;
        in_channel    = '0;
        in_data       = '0;
        in0_valid     = 1'b0;
        in0_channel   = '0;
        in0_data      = '0;
        cfg_ch_mask   = '0;
        cfg_clear_ovf = 1'b0;
        out_ready     = 1'b0;
        test_reset();
        test_average();
        test_signed_edges();
        test_interleave();
        test_overflow();
        test_full_pop_push();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
